// File: rtl/rp_sys_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : rp_sys_bus_initiator_if
// Description : Command, response and packed system-bus signals of the initiator
// Revision    : 1.0 - initial release
// ============================================================================
interface rp_sys_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic [69:0] sig;
  logic [33:0] bus_resp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel, bus_resp, rsp_ready,
    output cmd_ready, sig, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel, bus_resp, rsp_ready,
    input  cmd_ready, sig, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/rp_sys_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : rp_sys_bus_initiator
// Description : Single-outstanding system-bus initiator with response timeout
// Revision    : 1.0 - initial release
// ============================================================================
module rp_sys_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  wire logic                     system1000,
  input  wire logic                     system1000_rstn,
  rp_sys_bus_initiator_if.master        bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_read;
  logic [69:0]      r_sig;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_rsp_timeout;

  logic        w_ack;
  logic        w_err;
  logic        w_hit;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;
  logic [31:0] w_cap_rdata;

  assign w_ack    = bus.bus_resp[1];
  assign w_err    = bus.bus_resp[0];
  assign w_hit    = w_ack | w_err;
  assign w_accept = (r_state == ST_IDLE) & bus.cmd_valid;

  // Responders may answer combinationally, so the strobe cycle samples too.
  assign w_capture = ((r_state == ST_STROBE) | (r_state == ST_WAIT)) & w_hit;
  assign w_timeout = (r_state == ST_WAIT) & ~w_hit & (r_cnt == C_CNT_LAST);

  // err dominates ack; writes never return data.
  assign w_cap_rdata = (r_is_read & w_ack & ~w_err) ? bus.bus_resp[33:2] : 32'h0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_STROBE;
      ST_STROBE: w_state_nxt = w_hit ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (w_hit || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_is_read     <= 1'b0;
      r_sig         <= '0;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sig     <= {bus.cmd_addr, bus.cmd_wdata, bus.cmd_sel, bus.cmd_write, ~bus.cmd_write};
            r_is_read <= ~bus.cmd_write;
          end
        end
        ST_STROBE: begin
          r_sig[1:0] <= 2'b00;
          r_cnt      <= '0;
        end
        ST_WAIT: begin
          if (!w_hit && !w_timeout) r_cnt <= r_cnt + 1'b1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase

      if (w_capture) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= w_cap_rdata;
        r_rsp_err     <= w_err;
        r_rsp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= 32'h0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign bus.sig         = r_sig;
  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.busy        = r_busy;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rp_sys_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rp_sys_bus_initiator
// Description : Randomized self-checking bench for rp_sys_bus_initiator
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rp_sys_bus_initiator;

  localparam int TMO  = 8;
  localparam int NONE = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rp_sys_bus_initiator_if bif ();

  rp_sys_bus_initiator #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (16)
  ) u_dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .bus             (bif)
  );

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cmd();
    bif.cmd_valid = 1'($urandom);
    bif.cmd_write = 1'($urandom);
    bif.cmd_addr  = $urandom;
    bif.cmd_wdata = $urandom;
    bif.cmd_sel   = 4'($urandom);
  endtask

  // Reference: the response arrives 'lat' cycles after the strobe (0 = strobe
  // cycle); TMO idle cycles after the strobe are tolerated before a timeout.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int lat, input bit a, input bit e,
                         input logic [31:0] d, input int hold);
    bit          tmo;
    int          kend;
    logic [31:0] exp_rd;
    logic [67:0] held;
    tmo    = (lat > TMO);
    kend   = tmo ? TMO : lat;
    exp_rd = (!wr && a && !e && !tmo) ? d : 32'h0;
    held   = {addr, wdata, sel};

    check("idle_ready", {bif.cmd_ready, bif.busy, bif.rsp_valid}, 3'b100);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_addr  = addr;
    bif.cmd_wdata = wdata;
    bif.cmd_sel   = sel;
    bif.rsp_ready = 1'b0;
    bif.bus_resp  = {$urandom, 2'($urandom)};
    step();
    check("strobe_sig", bif.sig, {held, wr, ~wr});
    check("strobe_ctl", {bif.cmd_ready, bif.busy, bif.rsp_valid}, 3'b010);

    for (int k = 0; k <= kend; k++) begin
      scramble_cmd();
      bif.bus_resp = (k == lat) ? {d, a, e} : {$urandom, 2'b00};
      step();
      check("held_sig", bif.sig, {held, 2'b00});
      if (k < kend) check("wait_ctl", {bif.cmd_ready, bif.busy, bif.rsp_valid}, 3'b010);
    end
    check("rsp_flags", {bif.rsp_valid, bif.rsp_timeout, bif.rsp_err}, {1'b1, tmo, tmo | e});
    check("rsp_rdata", bif.rsp_rdata, exp_rd);

    for (int h = 0; h < hold; h++) begin
      scramble_cmd();
      bif.bus_resp = {$urandom, 2'($urandom)};
      step();
      check("hold_rsp", {bif.rsp_valid, bif.rsp_timeout, bif.rsp_err, bif.rsp_rdata},
            {1'b1, tmo, tmo | e, exp_rd});
      check("hold_ctl", {bif.sig, bif.cmd_ready, bif.busy}, {held, 2'b00, 1'b0, 1'b1});
    end

    bif.rsp_ready = 1'b1;
    bif.bus_resp  = {$urandom, 2'($urandom)};
    step();
    check("release", {bif.rsp_valid, bif.cmd_ready, bif.busy}, 3'b010);
    check("idle_sig", bif.sig, {held, 2'b00});
    bif.rsp_ready = 1'b0;
    bif.cmd_valid = 1'b0;
  endtask

  task automatic abort_txn();
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 32'h4030_0008;
    bif.cmd_wdata = 32'h0;
    bif.cmd_sel   = 4'hF;
    bif.bus_resp  = '0;
    step();
    bif.cmd_valid = 1'b0;
    step();
    step();
    check("abort_in_wait", {bif.busy, bif.rsp_valid}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {bif.sig, bif.busy, bif.rsp_valid, bif.cmd_ready}, {70'h0, 3'b001});
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.bus_resp = {32'hCAFE_0000 + 32'(i), 2'b10};
      step();
      check("no_stale_rsp", {bif.sig, bif.busy, bif.rsp_valid, bif.cmd_ready}, {70'h0, 3'b001});
    end
  endtask

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_wdata = '0;
    bif.cmd_sel   = '0;
    bif.bus_resp  = '0;
    bif.rsp_ready = 1'b0;
    #12;
    check("reset_out", {bif.sig, bif.busy, bif.rsp_valid, bif.cmd_ready}, {70'h0, 3'b001});
    check("reset_rsp", {bif.rsp_rdata, bif.rsp_err, bif.rsp_timeout}, 34'h0);
    step();
    rst_n = 1'b1;
    step();

    run_txn(1'b1, 32'h4030_0010, 32'hDEAD_BEEF, 4'hF, 0,    1'b1, 1'b0, 32'h5555_AAAA, 0);
    run_txn(1'b0, 32'h4030_0004, 32'h0,        4'hF, 3,    1'b1, 1'b0, 32'h1234_5678, 0);
    run_txn(1'b0, 32'h4FFF_0000, 32'h0,        4'hF, NONE, 1'b0, 1'b0, 32'h0,         1);
    run_txn(1'b0, 32'h4030_000C, 32'h0,        4'hF, 1,    1'b1, 1'b1, 32'hFFFF_FFFF, 0);
    run_txn(1'b0, 32'h4030_0014, 32'h0,        4'h3, 2,    1'b1, 1'b0, 32'h0BAD_F00D, 5);
    run_txn(1'b0, 32'h4030_0018, 32'h0,        4'hF, TMO,  1'b1, 1'b0, 32'h7777_1111, 0);
    abort_txn();
    run_txn(1'b0, 32'h4030_0020, 32'h0,        4'hF, 1,    1'b1, 1'b0, 32'hA5A5_5A5A, 0);

    for (int t = 0; t < 40; t++) begin
      int   kind;
      int   lat;
      kind = int'($urandom_range(0, 2));
      lat  = int'($urandom_range(0, TMO + 2));
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), lat,
              (kind != 1), (kind != 0), $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
